// File: rtl/clk_div_multi_if.sv
// Bus bundle for clk_div_multi: run enables, the half-period write and
// readback port, and the per-channel divided clock and tick outputs.
interface clk_div_multi_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = 4
);
  logic [NUM_CH-1:0] en;
  logic              wr_en;
  logic [CH_W-1:0]   wr_ch;
  logic [CNT_W-1:0]  wr_data;
  logic [CH_W-1:0]   rd_ch;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] clk_div;
  logic [NUM_CH-1:0] tick;

  modport master (
    output en, wr_en, wr_ch, wr_data, rd_ch,
    input  rd_data, clk_div, tick
  );

  modport slave (
    input  en, wr_en, wr_ch, wr_data, rd_ch,
    output rd_data, clk_div, tick
  );
endinterface

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider. Each channel counts up to its
// active half-period and toggles its output; the programmable shadow value
// is copied into the active register only at a toggle or while disabled,
// so a rewrite never shortens or stretches the phase in progress.
module clk_div_multi #(
  parameter int              NUM_CH       = 4,
  parameter int              CNT_W        = 32,
  parameter logic [CNT_W-1:0] DEFAULT_HALF = 1000,
  parameter int              CH_W         = 4
) (
  input logic            clk,
  input logic            reset,
  clk_div_multi_if.slave bus
);

  logic [CNT_W-1:0]  half_q [NUM_CH];
  logic [CNT_W-1:0]  half_d [NUM_CH];
  logic [CNT_W-1:0]  act_q  [NUM_CH];
  logic [CNT_W-1:0]  act_d  [NUM_CH];
  logic [CNT_W-1:0]  cnt_q  [NUM_CH];
  logic [CNT_W-1:0]  cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] clk_div_q, clk_div_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [CNT_W-1:0]  rd_data_c;

  // Next-state for shadow write, active reload, counters and outputs.
  always_comb begin
    half_d    = half_q;
    act_d     = act_q;
    cnt_d     = cnt_q;
    clk_div_d = clk_div_q;
    tick_d    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // Out-of-range channel addresses match no c and are dropped here.
      if (bus.wr_en && (bus.wr_ch == CH_W'(c))) begin
        half_d[c] = bus.wr_data;
      end
      if (bus.en[c]) begin
        if (cnt_q[c] == act_q[c]) begin
          cnt_d[c]     = '0;
          clk_div_d[c] = ~clk_div_q[c];
          tick_d[c]    = 1'b1;
          act_d[c]     = half_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + CNT_W'(1);
        end
      end else begin
        // Disabled: hold in a clean start state, ready for a full phase.
        cnt_d[c]     = '0;
        clk_div_d[c] = 1'b0;
        act_d[c]     = half_q[c];
      end
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        half_q[c] <= DEFAULT_HALF;
        act_q[c]  <= DEFAULT_HALF;
        cnt_q[c]  <= '0;
      end
      clk_div_q <= '0;
      tick_q    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        half_q[c] <= half_d[c];
        act_q[c]  <= act_d[c];
        cnt_q[c]  <= cnt_d[c];
      end
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
    end
  end

  // Readback mux of the shadow registers; unpopulated channels read 0.
  always_comb begin
    rd_data_c = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rd_ch == CH_W'(c)) begin
        rd_data_c = half_q[c];
      end
    end
  end

  assign bus.rd_data = rd_data_c;
  assign bus.clk_div = clk_div_q;
  assign bus.tick    = tick_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Bench for clk_div_multi: a down-counting reference model feeds a
// scoreboard every cycle, plus a readback vector table and hand-measured
// phase lengths for the corner cases.
module tb_clk_div_multi;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clk_div_multi_if #(.NUM_CH(NCH), .CNT_W(32), .CH_W(4)) bus ();

  clk_div_multi #(.NUM_CH(NCH), .CNT_W(32), .DEFAULT_HALF(1000), .CH_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [NCH-1:0] clk_div;
    logic [NCH-1:0] tick;
    logic [31:0]    rd;
  } exp_t;

  typedef struct {
    logic        wr_en;
    logic [3:0]  wr_ch;
    logic [31:0] wr_data;
    logic [3:0]  rd_ch;
    logic [31:0] exp_rd;
  } vec_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  logic [31:0]    m_half [NCH];
  logic [31:0]    m_rem  [NCH];
  logic [NCH-1:0] m_clk;
  logic [NCH-1:0] m_tick;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_half[c] = 32'd1000;
      m_rem[c]  = 32'd1000;
    end
    m_clk  = '0;
    m_tick = '0;
  endtask

  // Model: m_rem is the number of enabled edges left before the next toggle.
  task automatic model_step();
    logic [31:0] old_half [NCH];
    for (int c = 0; c < NCH; c++) old_half[c] = m_half[c];
    for (int c = 0; c < NCH; c++)
      if (bus.wr_en && int'(bus.wr_ch) == c) m_half[c] = bus.wr_data;
    for (int c = 0; c < NCH; c++) begin
      if (bus.en[c]) begin
        if (m_rem[c] == 0) begin
          m_clk[c]  = ~m_clk[c];
          m_tick[c] = 1'b1;
          m_rem[c]  = old_half[c];
        end else begin
          m_rem[c]  = m_rem[c] - 1;
          m_tick[c] = 1'b0;
        end
      end else begin
        m_clk[c]  = 1'b0;
        m_tick[c] = 1'b0;
        m_rem[c]  = old_half[c];
      end
    end
  endtask

  task automatic cycle();
    exp_t e, g;
    model_step();
    e.clk_div = m_clk;
    e.tick    = m_tick;
    e.rd      = (int'(bus.rd_ch) < NCH) ? m_half[bus.rd_ch] : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    chk("sb_clk_div", 32'(bus.clk_div), 32'(g.clk_div));
    chk("sb_tick", 32'(bus.tick), 32'(g.tick));
    chk("sb_rd_data", bus.rd_data, g.rd);
  endtask

  task automatic gap_to_tick(input int ch, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      cycle();
      if (bus.tick[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic edges_to_rise(input int ch, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      cycle();
      if (bus.clk_div[ch]) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t vt[9];
    int n, fr, tc0, tco, tc1, tc2, found;

    // Reset state
    reset = 1'b1;
    bus.en = '0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_data = '0; bus.rd_ch = '0;
    model_reset();
    #22;
    chk("rst_clk_div", 32'(bus.clk_div), 32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    chk("rst_rd_ch0", bus.rd_data, 32'd1000);
    reset = 1'b0;

    // Test 1: ch0 alone with default half-period
    bus.en = 4'b0001;
    fr = 0; tc0 = 0; tco = 0;
    for (int i = 1; i <= 5000; i++) begin
      cycle();
      if (bus.tick[0]) tc0++;
      if (bus.tick[3:1] != 0) tco++;
      if (fr == 0 && bus.clk_div[0]) fr = i;
    end
    chk("t1_first_rise", fr, 32'd1001);
    chk("t1_tick_count", tc0, 32'd4);
    chk("t1_other_ticks", tco, 32'd0);

    // Test 2: program ch1=0, ch2=3 while disabled, then enable all
    bus.en = '0;
    bus.wr_en = 1'b1; bus.wr_ch = 4'd1; bus.wr_data = 32'd0;
    cycle();
    bus.wr_ch = 4'd2; bus.wr_data = 32'd3;
    cycle();
    bus.wr_en = 1'b0;
    cycle();
    bus.en = 4'b1111;
    tc1 = 0; tc2 = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.tick[1]) tc1++;
      if (bus.tick[2]) tc2++;
    end
    chk("t2_ch1_ticks", tc1, 32'd40);
    chk("t2_ch2_ticks", tc2, 32'd10);

    // Test 3: rewrite ch2 on its exact boundary edge
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (m_rem[2] == 0) begin
        found = 1;
        break;
      end
      cycle();
    end
    chk("t3_found_boundary", found, 32'd1);
    bus.wr_en = 1'b1; bus.wr_ch = 4'd2; bus.wr_data = 32'd1;
    cycle();
    chk("t3_boundary_tick", 32'(bus.tick[2]), 32'd1);
    bus.wr_en = 1'b0;
    gap_to_tick(2, 20, n); chk("t3_gap_old", n, 32'd4);
    gap_to_tick(2, 20, n); chk("t3_gap_new1", n, 32'd2);
    gap_to_tick(2, 20, n); chk("t3_gap_new2", n, 32'd2);

    // Test 4: drop ch0 enable mid high phase, then re-enable
    found = 0;
    for (int i = 0; i < 2500; i++) begin
      if (m_clk[0] && m_rem[0] == 32'd500) begin
        found = 1;
        break;
      end
      cycle();
    end
    chk("t4_found_mid", found, 32'd1);
    chk("t4_high_before", 32'(bus.clk_div[0]), 32'd1);
    bus.en[0] = 1'b0;
    cycle();
    chk("t4_forced_low", 32'(bus.clk_div[0]), 32'd0);
    bus.en[0] = 1'b1;
    edges_to_rise(0, 1100, n);
    chk("t4_reenable_rise", n, 32'd1001);

    // Test 5: write/readback vectors
    vt[0] = '{1'b1, 4'd15, 32'hDEAD_BEEF, 4'd15, 32'd0};
    vt[1] = '{1'b0, 4'd0,  32'd0,         4'd0,  32'd1000};
    vt[2] = '{1'b0, 4'd0,  32'd0,         4'd1,  32'd0};
    vt[3] = '{1'b0, 4'd0,  32'd0,         4'd2,  32'd1};
    vt[4] = '{1'b0, 4'd0,  32'd0,         4'd3,  32'd1000};
    vt[5] = '{1'b1, 4'd1,  32'h0000_1234, 4'd1,  32'h0000_1234};
    vt[6] = '{1'b1, 4'd3,  32'hFFFF_FFFF, 4'd3,  32'hFFFF_FFFF};
    vt[7] = '{1'b0, 4'd0,  32'd0,         4'd15, 32'd0};
    vt[8] = '{1'b0, 4'd0,  32'd0,         4'd4,  32'd0};
    for (int i = 0; i < 9; i++) begin
      bus.wr_en = vt[i].wr_en; bus.wr_ch = vt[i].wr_ch;
      bus.wr_data = vt[i].wr_data; bus.rd_ch = vt[i].rd_ch;
      cycle();
      chk($sformatf("t5_vec%0d_rd", i), bus.rd_data, vt[i].exp_rd);
    end
    bus.wr_en = 1'b0;

    // Test 6: asynchronous reset mid-cycle with all channels running
    bus.en = 4'b1111; bus.rd_ch = 4'd1;
    for (int i = 0; i < 10; i++) cycle();
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_clk_div", 32'(bus.clk_div), 32'd0);
    chk("t6_async_tick", 32'(bus.tick), 32'd0);
    chk("t6_async_rd_ch1", bus.rd_data, 32'd1000);
    model_reset();
    #2;
    reset = 1'b0;
    edges_to_rise(0, 1100, n);
    chk("t6_resume_rise", n, 32'd1001);
    chk("t6_all_rise", 32'(bus.clk_div), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
